// File: rtl/ntt_r4_twiddle_gen_pkg.sv
// Shared NTT constants and the twiddle-generator state encoding.
package ntt_r4_twiddle_gen_pkg;

    localparam int unsigned N         = 17;
    localparam int unsigned CNTW      = 10;
    localparam int unsigned Q         = 65537;
    localparam int unsigned PW        = 2 * N;
    // 2^16 == -1 mod Q, so a product folds as lo16 - hi
    localparam int unsigned RED_SHIFT = 16;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        CU,
        OUT,
        STEP
    } ntt_state_e;

endpackage

// File: rtl/ntt_modmul.sv
// Combinational (a*b) mod Q for Q = 2^16+1, inputs in [0, Q-1].
module ntt_modmul
    import ntt_r4_twiddle_gen_pkg::*;
(
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] res_c
);

    logic [PW-1:0] prod;
    logic [N:0]    lo;
    logic [N:0]    hi;
    logic [N:0]    diff;

    // diff lies in [-2^16, 2^16-1]; a single add of Q fixes the negative side
    always_comb begin
        prod  = PW'(a_i) * PW'(b_i);
        lo    = (N+1)'(prod[RED_SHIFT-1:0]);
        hi    = prod[PW-1:RED_SHIFT];
        diff  = lo - hi;
        res_c = diff[N] ? N'(diff + (N+1)'(Q)) : N'(diff);
    end

endmodule

// File: rtl/ntt_r4_twiddle_gen.sv
// Radix-4 twiddle generator: emits (w^k, w^2k, w^3k) mod Q per group over valid/ready.
module ntt_r4_twiddle_gen
    import ntt_r4_twiddle_gen_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N-1:0]    w_step,
    input  logic [CNTW-1:0] n_groups,
    output logic            busy,
    output logic            done,
    output logic            tf_valid,
    input  logic            tf_ready,
    output logic [N-1:0]    tf1,
    output logic [N-1:0]    tf2,
    output logic [N-1:0]    tf3,
    output logic [CNTW-1:0] grp_idx
);

    ntt_state_e      state_q, state_d;
    logic [N-1:0]    tf1_q, tf1_d, tf2_q, tf2_d, tf3_q, tf3_d;
    logic [N-1:0]    w_q, w_d;
    logic [CNTW-1:0] k_q, k_d, n_q, n_d;
    logic            done_q, done_d, valid_q, valid_d, busy_q, busy_d;
    logic [N-1:0]    mul_a, mul_b, mul_res;

    ntt_modmul u_modmul (
        .a_i   (mul_a),
        .b_i   (mul_b),
        .res_c (mul_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tf1_q   <= N'(1);
            tf2_q   <= '0;
            tf3_q   <= '0;
            w_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tf1_q   <= tf1_d;
            tf2_q   <= tf2_d;
            tf3_q   <= tf3_d;
            w_q     <= w_d;
            k_q     <= k_d;
            n_q     <= n_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next state, datapath updates and multiplier operand muxing
    always_comb begin
        state_d = state_q;
        tf1_d   = tf1_q;
        tf2_d   = tf2_q;
        tf3_d   = tf3_q;
        w_d     = w_q;
        k_d     = k_q;
        n_d     = n_q;
        done_d  = 1'b0;
        mul_a   = tf1_q;
        mul_b   = tf1_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_groups == '0) begin
                        done_d = 1'b1;
                    end else begin
                        w_d     = w_step;
                        n_d     = n_groups;
                        tf1_d   = N'(1);
                        k_d     = '0;
                        state_d = SQ;
                    end
                end
            end
            SQ: begin
                tf2_d   = mul_res;
                state_d = CU;
            end
            CU: begin
                mul_a   = tf2_q;
                tf3_d   = mul_res;
                state_d = OUT;
            end
            OUT: begin
                if (valid_q && tf_ready) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                mul_b = w_q;
                tf1_d = mul_res;
                k_d   = k_q + CNTW'(1);
                if (k_q + CNTW'(1) == n_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SQ;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == OUT);
        busy_d  = (state_d != IDLE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign tf_valid = valid_q;
    assign tf1      = tf1_q;
    assign tf2      = tf2_q;
    assign tf3      = tf3_q;
    assign grp_idx  = k_q;

endmodule

// File: tb/tb_ntt_r4_twiddle_gen.sv
// Self-checking bench for ntt_r4_twiddle_gen against a modular-power reference model.
module tb_ntt_r4_twiddle_gen;

    localparam longint unsigned QM = 65537;

    logic        clk = 1'b0;
    logic        rst, start, tf_ready;
    logic [16:0] w_step;
    logic [9:0]  n_groups;
    logic        busy, done, tf_valid;
    logic [16:0] tf1, tf2, tf3;
    logic [9:0]  grp_idx;

    int n_checks = 0;
    int n_fail   = 0;

    ntt_r4_twiddle_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .w_step   (w_step),
        .n_groups (n_groups),
        .busy     (busy),
        .done     (done),
        .tf_valid (tf_valid),
        .tf_ready (tf_ready),
        .tf1      (tf1),
        .tf2      (tf2),
        .tf3      (tf3),
        .grp_idx  (grp_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] mpow(logic [16:0] b, int e);
        longint unsigned r = 1;
        for (int i = 0; i < e; i++) r = (r * longint'(b)) % QM;
        return 17'(r);
    endfunction

    function automatic logic [50:0] exp_tf(logic [16:0] w, int k);
        return {mpow(w, k), mpow(w, 2 * k), mpow(w, 3 * k)};
    endfunction

    task automatic kick(logic [16:0] w, logic [9:0] n);
        w_step   = w;
        n_groups = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tf_ready = 1'b0; w_step = '0; n_groups = '0;
        tick(); tick();
        n_checks++;
        if (tf1 !== 17'd1 || tf2 !== 17'd0 || tf3 !== 17'd0 || grp_idx !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_data: got tf=(%0d,%0d,%0d) grp=%0d expected (1,0,0) grp=0", tf1, tf2, tf3, grp_idx);
        end
        n_checks++;
        if ({tf_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid/busy/done=%b expected 000", {tf_valid, busy, done});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_base();
        logic [50:0] tab [3];
        int hs = 0, last = -1, done_cnt = 0, exp_c;
        tab[0] = {17'd1, 17'd1, 17'd1};
        tab[1] = {17'd3, 17'd9, 17'd27};
        tab[2] = {17'd9, 17'd81, 17'd729};
        tf_ready = 1'b1;
        kick(17'd3, 10'd3);
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (tf_valid) begin
                n_checks++;
                if (hs >= 3) begin
                    n_fail++;
                    $display("FAIL base_extra: got triple #%0d expected only 3", hs);
                end else if ({tf1, tf2, tf3} !== tab[hs] || grp_idx !== 10'(hs)) begin
                    n_fail++;
                    $display("FAIL base_triple: got (%0d,%0d,%0d) grp=%0d expected %h grp=%0d",
                             tf1, tf2, tf3, grp_idx, tab[hs], hs);
                end
                exp_c = (hs == 0) ? 2 : last + 4;
                n_checks++;
                if (cyc != exp_c) begin
                    n_fail++;
                    $display("FAIL base_timing: got valid at cycle %0d expected %0d", cyc, exp_c);
                end
                last = cyc;
                hs++;
            end
            if (done) begin
                done_cnt++;
                n_checks++;
                if (cyc != last + 2 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL base_done: got done at cycle %0d busy=%b expected cycle %0d busy=0",
                             cyc, busy, last + 2);
                end
            end
            tick();
        end
        n_checks++;
        if (hs != 3 || done_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL base_count: got %0d triples %0d dones busy=%b expected 3 1 0", hs, done_cnt, busy);
        end
    endtask

    task automatic test_reduction();
        logic [16:0] w;
        int n, hs, seen_done;
        tf_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            w  = (c == 0) ? 17'd65536 : 17'd256;
            n  = (c == 0) ? 2 : 5;
            hs = 0; seen_done = 0;
            kick(w, 10'(n));
            for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
                if (tf_valid) begin
                    n_checks++;
                    if ({tf1, tf2, tf3} !== exp_tf(w, hs) || grp_idx !== 10'(hs)) begin
                        n_fail++;
                        $display("FAIL red_triple: w=%0d k=%0d got (%0d,%0d,%0d) grp=%0d expected %h",
                                 w, hs, tf1, tf2, tf3, grp_idx, exp_tf(w, hs));
                    end
                    if ((c == 0 && hs == 1) || (c == 1 && hs == 2)) begin
                        n_checks++;
                        if ({tf1, tf2, tf3} !== {17'd65536, 17'd1, 17'd65536}) begin
                            n_fail++;
                            $display("FAIL red_minus1: w=%0d k=%0d got (%0d,%0d,%0d) expected (65536,1,65536)",
                                     w, hs, tf1, tf2, tf3);
                        end
                    end
                    if (c == 1 && hs == 4) begin
                        n_checks++;
                        if ({tf1, tf2, tf3} !== {17'd1, 17'd1, 17'd1}) begin
                            n_fail++;
                            $display("FAIL red_one: w=256 k=4 got (%0d,%0d,%0d) expected (1,1,1)", tf1, tf2, tf3);
                        end
                    end
                    hs++;
                end
                if (done) seen_done = 1;
                else tick();
            end
            n_checks++;
            if (hs != n || !seen_done) begin
                n_fail++;
                $display("FAIL red_count: w=%0d got %0d triples done=%0d expected %0d 1", w, hs, seen_done, n);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int hs = 0, stall = 7, seen_done = 0;
        tf_ready = 1'b1;
        kick(17'd3, 10'd3);
        for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
            if (tf_valid && grp_idx == 10'd1 && stall > 0) begin
                tf_ready = 1'b0;
                n_checks++;
                if ({tf1, tf2, tf3} !== {17'd3, 17'd9, 17'd27} || hs != 1) begin
                    n_fail++;
                    $display("FAIL bp_stable: got (%0d,%0d,%0d) after %0d triples expected (3,9,27) after 1",
                             tf1, tf2, tf3, hs);
                end
                stall--;
            end else begin
                tf_ready = 1'b1;
                if (tf_valid) begin
                    n_checks++;
                    if ({tf1, tf2, tf3} !== exp_tf(17'd3, hs) || grp_idx !== 10'(hs)) begin
                        n_fail++;
                        $display("FAIL bp_triple: got (%0d,%0d,%0d) grp=%0d expected %h grp=%0d",
                                 tf1, tf2, tf3, grp_idx, exp_tf(17'd3, hs), hs);
                    end
                    hs++;
                end
            end
            if (stall > 0 && hs == 1 && !tf_valid && grp_idx == 10'd1 && stall < 7) begin
                n_checks++;
                n_fail++;
                $display("FAIL bp_valid_drop: got tf_valid=0 during stall expected 1");
            end
            if (done) seen_done = 1;
            else tick();
        end
        n_checks++;
        if (hs != 3 || stall != 0 || !seen_done) begin
            n_fail++;
            $display("FAIL bp_count: got %0d triples stall_left=%0d done=%0d expected 3 0 1", hs, stall, seen_done);
        end
        tf_ready = 1'b1;
        tick();
    endtask

    task automatic test_zero_and_restart();
        int hs = 0, done_cnt = 0, bad_valid = 0;
        kick(17'd5, 10'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tf_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done/busy/valid=%b expected 100", {done, busy, tf_valid});
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            if (done || busy || tf_valid) bad_valid++;
        end
        n_checks++;
        if (bad_valid != 0) begin
            n_fail++;
            $display("FAIL zero_quiet: got %0d active cycles after pulse expected 0", bad_valid);
        end
        tf_ready = 1'b1;
        kick(17'd3, 10'd2);
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc == 4) begin
                w_step = 17'd7; n_groups = 10'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (tf_valid) begin
                n_checks++;
                if ({tf1, tf2, tf3} !== exp_tf(17'd3, hs) || grp_idx !== 10'(hs)) begin
                    n_fail++;
                    $display("FAIL restart_triple: got (%0d,%0d,%0d) grp=%0d expected %h grp=%0d",
                             tf1, tf2, tf3, grp_idx, exp_tf(17'd3, hs), hs);
                end
                hs++;
            end
            if (done) done_cnt++;
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (hs != 2 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL restart_ignored: got %0d triples %0d dones expected 2 1", hs, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0, bad = 0, hs = 0, seen_done = 0;
        tf_ready = 1'b1;
        kick(17'd3, 10'd3);
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            if (tf_valid && grp_idx == 10'd1) seen = 1;
            else tick();
        end
        rst = 1'b1; tf_ready = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if (!seen || tf1 !== 17'd1 || tf2 !== 17'd0 || tf3 !== 17'd0 || grp_idx !== 10'd0 ||
            {tf_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_state: reached=%0d got tf=(%0d,%0d,%0d) grp=%0d vbd=%b expected (1,0,0) 0 000",
                     seen, tf1, tf2, tf3, grp_idx, {tf_valid, busy, done});
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (done || tf_valid || busy) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad);
        end
        tf_ready = 1'b1;
        kick(17'd3, 10'd1);
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            if (tf_valid) begin
                n_checks++;
                if ({tf1, tf2, tf3} !== {17'd1, 17'd1, 17'd1} || grp_idx !== 10'd0) begin
                    n_fail++;
                    $display("FAIL midrst_restart: got (%0d,%0d,%0d) grp=%0d expected (1,1,1) grp=0",
                             tf1, tf2, tf3, grp_idx);
                end
                hs++;
            end
            if (done) seen_done = 1;
            else tick();
        end
        n_checks++;
        if (hs != 1 || !seen_done) begin
            n_fail++;
            $display("FAIL midrst_done: got %0d triples done=%0d expected 1 1", hs, seen_done);
        end
        tick();
    endtask

    task automatic test_random();
        logic [16:0] w;
        int n, hs, seen_done, cyc;
        for (int it = 0; it < 200; it++) begin
            w  = 17'($urandom_range(0, 65536));
            n  = int'($urandom_range(1, 16));
            hs = 0; seen_done = 0; cyc = 0;
            tf_ready = 1'b1;
            kick(w, 10'(n));
            while (!seen_done && cyc < 400) begin
                tf_ready = 1'($urandom_range(0, 1));
                if (tf_valid && tf_ready) begin
                    n_checks++;
                    if ({tf1, tf2, tf3} !== exp_tf(w, hs) || grp_idx !== 10'(hs)) begin
                        n_fail++;
                        $display("FAIL rand_triple: it=%0d w=%0d k=%0d got (%0d,%0d,%0d) grp=%0d expected %h",
                                 it, w, hs, tf1, tf2, tf3, grp_idx, exp_tf(w, hs));
                    end
                    hs++;
                end
                if (done) seen_done = 1;
                else tick();
                cyc++;
            end
            n_checks++;
            if (hs != n || !seen_done) begin
                n_fail++;
                $display("FAIL rand_count: it=%0d w=%0d got %0d triples done=%0d expected %0d 1",
                         it, w, hs, seen_done, n);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_base();
        test_reduction();
        test_backpressure();
        test_zero_and_restart();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
